// File: rtl/l2_request_arbiter.sv
// l2_request_arbiter: round-robin arbiter funnelling per-core L2 request packets
// into a single one-deep output register.
// Optional feature macro: L2_ARB_PERF_COUNTERS_EN enables the grant and stall
// performance counters; without it both perf outputs are tied to zero.
module l2_request_arbiter #(
    parameter int unsigned NUM_REQUESTERS = 4,
    parameter int unsigned PACKET_WIDTH   = 128,
    localparam int unsigned IDX_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic [NUM_REQUESTERS-1:0]                    req_valid,
    input  logic [NUM_REQUESTERS-1:0][PACKET_WIDTH-1:0]  req_packet,
    output logic [NUM_REQUESTERS-1:0]                    req_ready,
    output logic                                         out_valid,
    output logic [PACKET_WIDTH-1:0]                      out_packet,
    output logic [IDX_W-1:0]                             out_source,
    input  logic                                         out_ready,
    output logic [31:0]                                  perf_grant_count,
    output logic [31:0]                                  perf_stall_cycles
);

    logic                    out_valid_q,  out_valid_d;
    logic [PACKET_WIDTH-1:0] out_packet_q, out_packet_d;
    logic [IDX_W-1:0]        out_source_q, out_source_d;
    logic [IDX_W-1:0]        rr_ptr_q,     rr_ptr_d;

    logic                    slot_free;
    logic                    grant_any;
    logic [IDX_W-1:0]        grant_idx;
    logic [IDX_W:0]          scan_idx;

    // Round-robin search for the first valid requester at or after rr_ptr.
    always_comb begin
        slot_free = !out_valid_q || out_ready;
        grant_any = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        if (!reset && slot_free) begin
            for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
                scan_idx = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
                if (scan_idx >= (IDX_W+1)'(NUM_REQUESTERS)) begin
                    scan_idx = scan_idx - (IDX_W+1)'(NUM_REQUESTERS);
                end
                if (!grant_any && req_valid[scan_idx[IDX_W-1:0]]) begin
                    grant_any = 1'b1;
                    grant_idx = scan_idx[IDX_W-1:0];
                end
            end
        end
    end

    // One-hot accept strobe on the granted core.
    always_comb begin
        req_ready = '0;
        if (grant_any) begin
            req_ready = NUM_REQUESTERS'(1) << grant_idx;
        end
    end

    // Output register and pointer next state.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_packet_d = out_packet_q;
        out_source_d = out_source_q;
        rr_ptr_d     = rr_ptr_q;
        if (grant_any) begin
            out_valid_d  = 1'b1;
            out_packet_d = req_packet[grant_idx];
            out_source_d = grant_idx;
            rr_ptr_d     = (grant_idx == IDX_W'(NUM_REQUESTERS - 1)) ? '0 : grant_idx + IDX_W'(1);
        end else if (out_valid_q && out_ready) begin
            out_valid_d  = 1'b0;
        end
    end

    // State registers; reset discards any held packet.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_packet_q <= '0;
            out_source_q <= '0;
            rr_ptr_q     <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_packet_q <= out_packet_d;
            out_source_q <= out_source_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_packet = out_packet_q;
    assign out_source = out_source_q;

`ifdef L2_ARB_PERF_COUNTERS_EN
    logic [31:0] perf_grant_q, perf_grant_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // Grant and stall counters, free-running with natural wrap.
    always_comb begin
        perf_grant_d = perf_grant_q;
        perf_stall_d = perf_stall_q;
        if (grant_any) begin
            perf_grant_d = perf_grant_q + 32'd1;
        end
        if ((|req_valid) && !grant_any) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_grant_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_grant_q <= perf_grant_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_grant_count  = perf_grant_q;
    assign perf_stall_cycles = perf_stall_q;
`else
    assign perf_grant_count  = 32'd0;
    assign perf_stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Directed testbench for l2_request_arbiter with a packet/source scoreboard.
module tb_l2_request_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned PW = 128;

    typedef struct packed {
        logic [PW-1:0] pkt;
        logic [1:0]    src;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [N-1:0]          req_valid;
    logic [N-1:0][PW-1:0]  req_packet;
    logic [N-1:0]          req_ready;
    logic                  out_valid;
    logic [PW-1:0]         out_packet;
    logic [1:0]            out_source;
    logic                  out_ready;
    logic [31:0]           perf_grant_count;
    logic [31:0]           perf_stall_cycles;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    logic [PW-1:0] pk [N];

    l2_request_arbiter #(.NUM_REQUESTERS(N), .PACKET_WIDTH(PW)) dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_packet        (req_packet),
        .req_ready         (req_ready),
        .out_valid         (out_valid),
        .out_packet        (out_packet),
        .out_source        (out_source),
        .out_ready         (out_ready),
        .perf_grant_count  (perf_grant_count),
        .perf_stall_cycles (perf_stall_cycles)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [PW-1:0] act, logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic push(input int i);
        exp_t e;
        e.pkt = pk[i];
        e.src = 2'(i);
        sb.push_back(e);
    endtask

    // Scoreboard monitor: every packet the L2 consumes must match the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got pkt %0h src %0d expected none", out_packet, out_source);
            end else begin
                e = sb.pop_front();
                chk("sb_pkt", out_packet, e.pkt);
                chk("sb_src", PW'(out_source), PW'(e.src));
            end
        end
    end

`ifndef L2_ARB_PERF_COUNTERS_EN
    // Without counters both perf outputs stay zero in every cycle.
    always @(negedge clk) begin
        chk("perf_grant_off", PW'(perf_grant_count), '0);
        chk("perf_stall_off", PW'(perf_stall_cycles), '0);
    end
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        pk[0] = 128'h0000_1111_2222_3333_4444_5555_6666_7770;
        pk[1] = 128'h0000_1111_2222_3333_4444_5555_6666_7771;
        pk[2] = 128'h0000_0000_0000_0000_0000_0000_0000_00A5;
        pk[3] = 128'hDEAD_BEEF_0000_0000_0000_0000_CAFE_F00D;
        for (int i = 0; i < N; i++) req_packet[i] = pk[i];
        reset     = 1'b1;
        req_valid = '0;
        out_ready = 1'b0;
        next();
        next();

        // Reset state, with requests pending during reset.
        req_valid = 4'hF;
        samp();
        chk("rst_req_ready", PW'(req_ready), '0);
        chk("rst_out_valid", PW'(out_valid), '0);
        chk("rst_rr_ptr",    PW'(dut.rr_ptr_q), '0);
        chk("rst_perf_grant", PW'(perf_grant_count), '0);
        chk("rst_perf_stall", PW'(perf_stall_cycles), '0);
        next();

        // Single requester, core 2.
        reset = 1'b0; req_valid = 4'b0100; out_ready = 1'b1;
        push(2);
        samp();
        chk("t1_req_ready", PW'(req_ready), PW'(4'b0100));
        next();
        req_valid = '0;
        samp();
        chk("t1_out_valid",  PW'(out_valid), PW'(1));
        chk("t1_out_packet", out_packet, PW'(8'hA5));
        chk("t1_out_source", PW'(out_source), PW'(2));
        chk("t1_rr_ptr",     PW'(dut.rr_ptr_q), PW'(3));
        next();
        samp();
        chk("t1_drained", PW'(out_valid), '0);
        next();

        // All cores valid from reset: 0,1,2,3,0,1 back to back.
        reset = 1'b1;
        next();
        reset = 1'b0; req_valid = 4'hF;
        for (int k = 0; k < 6; k++) begin
            push(k % 4);
            samp();
            chk("t2_req_ready", PW'(req_ready), PW'(4'b0001 << (k % 4)));
            next();
        end
        req_valid = '0;
        samp();
        chk("t2_rr_ptr", PW'(dut.rr_ptr_q), PW'(2));
        next();

        // Backpressure: output held for 3 cycles while cores 0 and 1 wait.
        out_ready = 1'b0; req_valid = 4'b0001;
        push(0);
        samp();
        chk("t3_setup_ready", PW'(req_ready), PW'(4'b0001));
        next();
        req_valid = 4'b0011;
        for (int k = 0; k < 3; k++) begin
            samp();
            chk("t3_stall_ready", PW'(req_ready), '0);
            chk("t3_stall_valid", PW'(out_valid), PW'(1));
            chk("t3_stall_pkt",   out_packet, pk[0]);
            next();
        end
        out_ready = 1'b1;
        push(1);
        samp();
        chk("t3_resume_ready", PW'(req_ready), PW'(4'b0010));
`ifdef L2_ARB_PERF_COUNTERS_EN
        chk("t3_perf_stall", PW'(perf_stall_cycles), PW'(3));
        chk("t3_perf_grant", PW'(perf_grant_count), PW'(7));
`endif
        next();
        req_valid = 4'b0001;
        push(0);
        samp();
        chk("t3_core0_ready", PW'(req_ready), PW'(4'b0001));
        next();
        req_valid = '0;
        samp();
        next();

        // Wrap-around from rr_ptr=3 with cores 0 and 3.
        req_valid = 4'b0100;
        push(2);
        samp();
        chk("t4_pre_ready", PW'(req_ready), PW'(4'b0100));
        next();
        req_valid = 4'b1001;
        push(3);
        samp();
        chk("t4_rr_ptr3", PW'(dut.rr_ptr_q), PW'(3));
        chk("t4_grant_a", PW'(req_ready), PW'(4'b1000));
        next();
        push(0);
        samp();
        chk("t4_grant_b", PW'(req_ready), PW'(4'b0001));
        next();
        push(3);
        samp();
        chk("t4_grant_c", PW'(req_ready), PW'(4'b1000));
        next();
        req_valid = '0;
        samp();
        chk("t4_rr_ptr0", PW'(dut.rr_ptr_q), '0);
        next();

        // Reset while a packet is held; it must be discarded.
        out_ready = 1'b0; req_valid = 4'b1000;
        push(3);
        samp();
        chk("t5_hold_ready", PW'(req_ready), PW'(4'b1000));
        next();
        req_valid = '0; reset = 1'b1;
        sb.delete();
        samp();
        chk("t5_rst_ready", PW'(req_ready), '0);
        chk("t5_held_valid", PW'(out_valid), PW'(1));
        next();
        reset = 1'b0; req_valid = 4'b0110; out_ready = 1'b1;
        push(1);
        samp();
        chk("t5_post_valid", PW'(out_valid), '0);
        chk("t5_post_rr",    PW'(dut.rr_ptr_q), '0);
        chk("t5_post_grant_cnt", PW'(perf_grant_count), '0);
        chk("t5_post_stall_cnt", PW'(perf_stall_cycles), '0);
        chk("t5_first_grant", PW'(req_ready), PW'(4'b0010));
        next();
        req_valid = 4'b0100;
        push(2);
        samp();
        chk("t5_second_grant", PW'(req_ready), PW'(4'b0100));
        next();
        req_valid = '0;
        samp();
        next();

        // Grant counter wrap from all-ones.
        req_valid = 4'b0001;
        push(0);
`ifdef L2_ARB_PERF_COUNTERS_EN
        force dut.perf_grant_q = 32'hFFFF_FFFF;
`endif
        samp();
`ifdef L2_ARB_PERF_COUNTERS_EN
        release dut.perf_grant_q;
`endif
        chk("t6_req_ready", PW'(req_ready), PW'(4'b0001));
        next();
        req_valid = '0;
        samp();
        chk("t6_perf_grant_wrap", PW'(perf_grant_count), '0);
        next();
        samp();
        chk("sb_empty", PW'(sb.size()), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/l2_request_arbiter.md
L2_REQUEST_ARBITER -- requirements
Module: l2_request_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQUESTERS, default 4, meaning number of cores sharing the L2 request port (2..16).
REQ-002 The block SHALL have parameter PACKET_WIDTH, default 128, meaning width in bits of one L2 request packet.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port req_valid  input  NUM_REQUESTERS  per-core request pending.
REQ-006 The block SHALL have port req_packet  input  NUM_REQUESTERS x PACKET_WIDTH  per-core request packet.
REQ-007 The block SHALL have port req_ready  output  NUM_REQUESTERS  per-core accept strobe; at most one bit high per cycle.
REQ-008 The block SHALL have port out_valid  output  1  output register holds a packet for the L2.
REQ-009 The block SHALL have port out_packet  output  PACKET_WIDTH  granted packet.
REQ-010 The block SHALL have port out_source  output  $clog2(NUM_REQUESTERS)  index of core that issued out_packet.
REQ-011 The block SHALL have port out_ready  input  1  L2 consumes out_packet this cycle when out_valid is high.
REQ-012 The block SHALL have port perf_grant_count  output  32  total packets accepted.
REQ-013 The block SHALL have port perf_stall_cycles  output  32  cycles with any req_valid high and no req_ready high.

Function
REQ-014 The block SHALL define slot_free = !out_valid || out_ready, evaluated combinationally in the current cycle.
REQ-015 When slot_free and any req_valid bit is high, the block SHALL grant the first valid requester at or after rr_ptr, searching upward and wrapping from NUM_REQUESTERS-1 to 0.
REQ-016 req_ready SHALL be one-hot on the granted index and all-zero when no grant occurs; req_ready SHALL be a combinational function of req_valid, rr_ptr, out_valid and out_ready.
REQ-017 On a grant the block SHALL, at the next edge, load out_packet from the granted req_packet, load out_source with the granted index, set out_valid, and set rr_ptr to (granted index + 1) mod NUM_REQUESTERS.
REQ-018 When out_valid && out_ready and no grant occurs, out_valid SHALL clear at the next edge; out_packet and out_source SHALL hold their values.
REQ-019 When !slot_free, out_valid, out_packet, out_source and rr_ptr SHALL hold, and req_ready SHALL be zero.
REQ-020 When no grant occurs, rr_ptr SHALL hold.
REQ-021 Grant-to-output latency SHALL be exactly one cycle; sustained throughput SHALL be one packet per cycle while out_ready is held high.
REQ-022 Requesters SHALL hold req_valid and req_packet stable until req_ready; the block SHALL NOT buffer more than the one output packet.
REQ-023 With all requesters continuously valid, each requester SHALL be granted exactly once in every NUM_REQUESTERS consecutive grants (no starvation).

Reset
REQ-024 While reset is high at a clock edge, the block SHALL clear out_valid, out_packet, out_source, rr_ptr, perf_grant_count and perf_stall_cycles to 0.
REQ-025 req_ready SHALL be all-zero in any cycle where reset is high.
REQ-026 A packet held in the output register when reset asserts SHALL be discarded and not presented after reset.

Configuration
REQ-027 With macro L2_ARB_PERF_COUNTERS_EN defined, perf_grant_count SHALL increment by 1 per grant and perf_stall_cycles by 1 per stall cycle, both wrapping from 0xFFFFFFFF to 0.
REQ-028 Without L2_ARB_PERF_COUNTERS_EN, both perf outputs SHALL be constant 0 and no counter registers SHALL be synthesized; all other behaviour SHALL be identical.

Verification
REQ-029 Bench: N=4, only core 2 valid with packet 0xA5, out_ready=1 -> req_ready=0b0100 same cycle; next cycle out_valid=1, out_packet=0xA5, out_source=2, rr_ptr=3.
REQ-030 Bench: all four cores valid continuously, out_ready=1, from reset -> out_source sequence 0,1,2,3,0,1 on consecutive cycles.
REQ-031 Bench: out_valid=1, out_ready=0 for 3 cycles with cores 0 and 1 valid -> req_ready=0 and out_packet stable for 3 cycles; perf_stall_cycles increases by 3 (macro on).
REQ-032 Bench: rr_ptr=3, only cores 0 and 3 valid -> core 3 granted, then core 0, then core 3 (wrap-around).
REQ-033 Bench: assert reset while out_valid=1 -> next cycle out_valid=0, rr_ptr=0, counters=0; first grant after release goes to lowest valid index.
REQ-034 Bench: macro on, preload perf_grant_count=0xFFFFFFFF via forced state, one grant -> perf_grant_count=0; macro off -> both perf outputs 0 throughout.
